// File: rtl/mc8051_mem_resp_if.sv
// ---------------------------------------------------------------------------
// mc8051_mem_resp_if
//
// Purpose: bundles every bus between the mc8051 core, the memory responder,
// the SFR block and the external code/xdata bus.
//
// Signal groups (directions shown from the responder's side):
//   Core request   : i_mem_req, i_mem_we, i_mem_space[1:0], i_mem_addr[15:0],
//                    i_mem_wdata[7:0]                              (in)
//   Core response  : o_mem_rdata[7:0], o_mem_ready, o_mem_err      (out)
//   SFR strobe bus : o_sfr_addr[7:0], o_sfr_we, o_sfr_re,
//                    o_sfr_wdata[7:0] (out); i_sfr_rdata[7:0]      (in)
//   External bus   : o_xbus_req, o_xbus_we, o_xbus_code,
//                    o_xbus_addr[15:0], o_xbus_wdata[7:0]          (out)
//                    i_xbus_ack, i_xbus_rdata[7:0]                 (in)
//
// Modports:
//   slave  : the memory responder (mc8051_mem_resp).
//   master : everything around it (core, SFR block, external bus model).
// ---------------------------------------------------------------------------
interface mc8051_mem_resp_if;

  // Core request
  logic        i_mem_req;
  logic        i_mem_we;
  logic [1:0]  i_mem_space;
  logic [15:0] i_mem_addr;
  logic [7:0]  i_mem_wdata;

  // Core response
  logic [7:0]  o_mem_rdata;
  logic        o_mem_ready;
  logic        o_mem_err;

  // SFR strobe bus
  logic [7:0]  o_sfr_addr;
  logic        o_sfr_we;
  logic        o_sfr_re;
  logic [7:0]  o_sfr_wdata;
  logic [7:0]  i_sfr_rdata;

  // External code/xdata bus
  logic        o_xbus_req;
  logic        o_xbus_we;
  logic        o_xbus_code;
  logic [15:0] o_xbus_addr;
  logic [7:0]  o_xbus_wdata;
  logic        i_xbus_ack;
  logic [7:0]  i_xbus_rdata;

  modport slave (
    input  i_mem_req, i_mem_we, i_mem_space, i_mem_addr, i_mem_wdata,
    output o_mem_rdata, o_mem_ready, o_mem_err,
    output o_sfr_addr, o_sfr_we, o_sfr_re, o_sfr_wdata,
    input  i_sfr_rdata,
    output o_xbus_req, o_xbus_we, o_xbus_code, o_xbus_addr, o_xbus_wdata,
    input  i_xbus_ack, i_xbus_rdata
  );

  modport master (
    output i_mem_req, i_mem_we, i_mem_space, i_mem_addr, i_mem_wdata,
    input  o_mem_rdata, o_mem_ready, o_mem_err,
    input  o_sfr_addr, o_sfr_we, o_sfr_re, o_sfr_wdata,
    output i_sfr_rdata,
    input  o_xbus_req, o_xbus_we, o_xbus_code, o_xbus_addr, o_xbus_wdata,
    output i_xbus_ack, i_xbus_rdata
  );

endinterface

// File: rtl/mc8051_mem_resp.sv
// ---------------------------------------------------------------------------
// mc8051_mem_resp
//
// Purpose: memory-side responder for the mc8051 core. Each single-cycle
// request is routed by address space to the internal data RAM (IRAM), the
// SFR strobe bus or the external code/xdata bus, and is always completed by
// a single-cycle o_mem_ready pulse carrying the read data.
//
// Ports:
//   i_clk  : core clock (single clock domain)
//   i_rst  : synchronous, active-high reset
//   bus    : mc8051_mem_resp_if.slave -- core request/response, SFR strobe
//            bus and external bus (see the interface file for the list)
//
// Parameters:
//   XBUS_TIMEOUT : wait-counter value at which an unacknowledged external
//                  access is forced to complete with rdata 0xFF and o_mem_err.
//
// Configuration macro:
//   MC8051_IRAM_256_EN : when defined the IRAM is 256 bytes and indirect
//                        accesses to 0x80-0xFF reach the upper half. When
//                        undefined the IRAM is 128 bytes; indirect reads of
//                        0x80-0xFF return 0xFF and writes there are dropped.
//                        Direct 0x80-0xFF is always the SFR bus.
//
// Latency:
//   IRAM / SFR : request sampled at edge N -> ready in cycle N+1.
//   xbus       : ack sampled at edge M    -> ready in cycle M+1
//                timeout                  -> ready XBUS_TIMEOUT+2 cycles
//                                            after the request.
// ---------------------------------------------------------------------------
module mc8051_mem_resp #(
  parameter logic [7:0] XBUS_TIMEOUT = 8'd255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mc8051_mem_resp_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Types and IRAM geometry
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_XWAIT = 2'd2,
    ST_XDONE = 2'd3
  } state_t;

  // Selects what o_mem_rdata shows during the RESP cycle.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,   // IRAM write / discarded write
    SRC_IRAM = 2'd1,   // registered IRAM read data
    SRC_SFR  = 2'd2,   // combinational SFR read data
    SRC_ONES = 2'd3    // unimplemented upper IRAM read
  } src_t;

  localparam logic [1:0] SPACE_IDATA = 2'b00;
  localparam logic [1:0] SPACE_DIRECT = 2'b01;

`ifdef MC8051_IRAM_256_EN
  localparam int IRAM_AW = 8;
`else
  localparam int IRAM_AW = 7;
`endif
  localparam int IRAM_DEPTH = 1 << IRAM_AW;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t       state_q, state_d;
  src_t         src_q, src_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   xrdata_q, xrdata_d;
  logic         err_q, err_d;

  logic [7:0]   sfr_addr_q, sfr_addr_d;
  logic [7:0]   sfr_wdata_q, sfr_wdata_d;
  logic         sfr_we_q, sfr_we_d;
  logic         sfr_re_q, sfr_re_d;

  logic         xbus_we_q, xbus_we_d;
  logic         xbus_code_q, xbus_code_d;
  logic [15:0]  xbus_addr_q, xbus_addr_d;
  logic [7:0]   xbus_wdata_q, xbus_wdata_d;

  // IRAM storage and its registered read port
  logic [7:0]          iram_mem [0:IRAM_DEPTH-1];
  logic [7:0]          iram_rdata_q;
  logic                iram_we;
  logic                iram_re;
  logic [IRAM_AW-1:0]  iram_idx;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic accept;
  logic upper;
  logic is_iram;
  logic is_sfr;
  logic is_xbus;
  logic is_void;   // indirect upper half with no upper IRAM present

  always_comb begin
    // A request is only taken when no external access is in flight; one
    // arriving in XWAIT/XDONE is silently dropped.
    accept   = bus.i_mem_req && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    upper    = bus.i_mem_addr[7];
    is_xbus  = bus.i_mem_space[1];
    is_sfr   = (bus.i_mem_space == SPACE_DIRECT) && upper;
`ifdef MC8051_IRAM_256_EN
    is_iram  = !is_xbus && !is_sfr;
    is_void  = 1'b0;
`else
    is_iram  = !is_xbus && !upper;
    is_void  = (bus.i_mem_space == SPACE_IDATA) && upper;
`endif
    iram_idx = bus.i_mem_addr[IRAM_AW-1:0];
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    xrdata_d     = xrdata_q;
    err_d        = err_q;
    sfr_addr_d   = sfr_addr_q;
    sfr_wdata_d  = sfr_wdata_q;
    sfr_we_d     = 1'b0;        // strobes live for exactly one RESP cycle
    sfr_re_d     = 1'b0;
    xbus_we_d    = xbus_we_q;
    xbus_code_d  = xbus_code_q;
    xbus_addr_d  = xbus_addr_q;
    xbus_wdata_d = xbus_wdata_q;
    iram_we      = 1'b0;
    iram_re      = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (is_xbus) begin
            // Latch the external request; it is held until XDONE.
            state_d      = ST_XWAIT;
            cnt_d        = 8'd0;
            err_d        = 1'b0;
            xbus_we_d    = bus.i_mem_we;
            xbus_code_d  = bus.i_mem_space[0];
            xbus_addr_d  = bus.i_mem_addr;
            xbus_wdata_d = bus.i_mem_wdata;
          end else begin
            state_d = ST_RESP;
            if (is_sfr) begin
              src_d       = SRC_SFR;
              sfr_addr_d  = bus.i_mem_addr[7:0];
              sfr_wdata_d = bus.i_mem_wdata;
              sfr_we_d    = bus.i_mem_we;
              sfr_re_d    = !bus.i_mem_we;
            end else if (is_void) begin
              src_d = bus.i_mem_we ? SRC_ZERO : SRC_ONES;
            end else if (is_iram) begin
              src_d   = bus.i_mem_we ? SRC_ZERO : SRC_IRAM;
              iram_we = bus.i_mem_we && !i_rst;
              iram_re = !bus.i_mem_we;
            end else begin
              src_d = SRC_ZERO;
            end
          end
        end
      end

      ST_XWAIT: begin
        // Ack is checked first so that an ack coincident with the timeout
        // still completes normally.
        if (bus.i_xbus_ack) begin
          state_d  = ST_XDONE;
          xrdata_d = bus.i_xbus_rdata;
          err_d    = 1'b0;
        end else if (cnt_q == XBUS_TIMEOUT) begin
          state_d  = ST_XDONE;
          xrdata_d = 8'hFF;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_XDONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_ZERO;
      cnt_q        <= 8'd0;
      xrdata_q     <= 8'h00;
      err_q        <= 1'b0;
      sfr_addr_q   <= 8'h00;
      sfr_wdata_q  <= 8'h00;
      sfr_we_q     <= 1'b0;
      sfr_re_q     <= 1'b0;
      xbus_we_q    <= 1'b0;
      xbus_code_q  <= 1'b0;
      xbus_addr_q  <= 16'h0000;
      xbus_wdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      xrdata_q     <= xrdata_d;
      err_q        <= err_d;
      sfr_addr_q   <= sfr_addr_d;
      sfr_wdata_q  <= sfr_wdata_d;
      sfr_we_q     <= sfr_we_d;
      sfr_re_q     <= sfr_re_d;
      xbus_we_q    <= xbus_we_d;
      xbus_code_q  <= xbus_code_d;
      xbus_addr_q  <= xbus_addr_d;
      xbus_wdata_q <= xbus_wdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // IRAM: synchronous write, registered read, contents survive reset.
  // A read issued the cycle after a write to the same address sees the new
  // value because the write has already landed on the previous edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (iram_we) begin
      iram_mem[iram_idx] <= bus.i_mem_wdata;
    end
    if (iram_re) begin
      iram_rdata_q <= iram_mem[iram_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.o_mem_ready = 1'b0;
    bus.o_mem_rdata = 8'h00;
    bus.o_mem_err   = 1'b0;
    case (state_q)
      ST_RESP: begin
        bus.o_mem_ready = 1'b1;
        case (src_q)
          SRC_IRAM: bus.o_mem_rdata = iram_rdata_q;
          SRC_SFR:  bus.o_mem_rdata = bus.i_sfr_rdata;
          SRC_ONES: bus.o_mem_rdata = 8'hFF;
          default:  bus.o_mem_rdata = 8'h00;
        endcase
      end
      ST_XDONE: begin
        bus.o_mem_ready = 1'b1;
        bus.o_mem_rdata = xrdata_q;
        bus.o_mem_err   = err_q;
      end
      default: begin
        bus.o_mem_ready = 1'b0;
      end
    endcase
  end

  assign bus.o_sfr_addr   = sfr_addr_q;
  assign bus.o_sfr_wdata  = sfr_wdata_q;
  assign bus.o_sfr_we     = sfr_we_q;
  assign bus.o_sfr_re     = sfr_re_q;

  // The request is simply "waiting on the bus", so a reset mid-access
  // drops it on the reset edge.
  assign bus.o_xbus_req   = (state_q == ST_XWAIT);
  assign bus.o_xbus_we    = xbus_we_q;
  assign bus.o_xbus_code  = xbus_code_q;
  assign bus.o_xbus_addr  = xbus_addr_q;
  assign bus.o_xbus_wdata = xbus_wdata_q;

endmodule
